// File: rtl/i2c_bit_if.sv
// Command/status and pad bundle between the byte layer and the I2C bit engine.
interface i2c_bit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ena;
  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       cmd;
  logic             din;
  logic             cmd_ack;
  logic             dout;
  logic             busy;
  logic             al;
  logic             scl_pad_i;
  logic             scl_pad_o;
  logic             scl_padoen_o;
  logic             sda_pad_i;
  logic             sda_pad_o;
  logic             sda_padoen_o;

  // Byte layer side: issues commands and sees the resolved bus lines.
  modport master (
    output ena, clk_cnt, cmd, din, scl_pad_i, sda_pad_i,
    input  cmd_ack, dout, busy, al,
           scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o
  );

  // Bit engine side.
  modport slave (
    input  ena, clk_cnt, cmd, din, scl_pad_i, sda_pad_i,
    output cmd_ack, dout, busy, al,
           scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o
  );
endinterface

// File: rtl/i2c_bit_ctrl.sv
// I2C bit engine: turns one-hot START/STOP/WRITE/READ commands into
// open-drain SCL/SDA phases, with clock stretching, bus-busy tracking
// and arbitration-lost detection.
module i2c_bit_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic     wb_clk_i,
  input  logic     wb_rst_i,
  i2c_bit_if.slave bus
);

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [4:0] {
    S_IDLE,
    S_STA_A, S_STA_B, S_STA_C, S_STA_D, S_STA_E,
    S_STO_A, S_STO_B, S_STO_C, S_STO_D,
    S_WR_A,  S_WR_B,  S_WR_C,  S_WR_D,
    S_RD_A,  S_RD_B,  S_RD_C,  S_RD_D
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_scl_oen, w_scl_oen_nxt;
  logic             r_sda_oen, w_sda_oen_nxt;
  logic             r_cmd_ack, w_cmd_ack_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_cmd_stop, w_cmd_stop_nxt;

  logic             r_scl_s1, r_scl_s2, r_scl_s3;
  logic             r_sda_s1, r_sda_s2, r_sda_s3;
  logic             r_scl_oen_d1, r_scl_oen_d2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_al;

  logic             w_stall;
  logic             w_clk_en;
  logic             w_sta_det;
  logic             w_sto_det;
  logic             w_al;
  logic             w_cmd_ok;

  // Line is held low by someone else while we released it (2-cycle aligned with the synchronizer).
  assign w_stall   = r_scl_oen_d2 & ~r_scl_s2;
  assign w_clk_en  = (r_cnt == '0) & ~w_stall;
  // Bus conditions need SCL high on both sides of the SDA edge.
  assign w_sta_det = r_sda_s3 & ~r_sda_s2 & r_scl_s2 & r_scl_s3;
  assign w_sto_det = ~r_sda_s3 & r_sda_s2 & r_scl_s2 & r_scl_s3;
  // r_cmd_stop covers our own STOP even when detection lands after the FSM is back in IDLE.
  assign w_al      = (r_sda_oen & ~r_sda_s2 & ((r_state == S_WR_B) || (r_state == S_WR_C)))
                   | (w_sto_det & ~r_cmd_stop);
  assign w_cmd_ok  = (bus.cmd == CMD_START) || (bus.cmd == CMD_STOP) ||
                     (bus.cmd == CMD_WRITE) || (bus.cmd == CMD_READ);

  // Pad input synchronizers, edge-detect delay and SCL-enable delay for stretch detection.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_scl_s1     <= 1'b1;
      r_scl_s2     <= 1'b1;
      r_scl_s3     <= 1'b1;
      r_sda_s1     <= 1'b1;
      r_sda_s2     <= 1'b1;
      r_sda_s3     <= 1'b1;
      r_scl_oen_d1 <= 1'b1;
      r_scl_oen_d2 <= 1'b1;
    end else begin
      r_scl_s1     <= bus.scl_pad_i;
      r_scl_s2     <= r_scl_s1;
      r_scl_s3     <= r_scl_s2;
      r_sda_s1     <= bus.sda_pad_i;
      r_sda_s2     <= r_sda_s1;
      r_sda_s3     <= r_sda_s2;
      r_scl_oen_d1 <= r_scl_oen;
      r_scl_oen_d2 <= r_scl_oen_d1;
    end
  end

  // Phase prescaler: reload in IDLE/disabled and at terminal count, hold while stretched.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cnt <= bus.clk_cnt;
    end else if ((r_state == S_IDLE) || !bus.ena || w_clk_en) begin
      r_cnt <= bus.clk_cnt;
    end else if (!w_stall) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Bus-busy tracking and arbitration-lost pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_busy <= 1'b0;
      r_al   <= 1'b0;
    end else begin
      if (w_sta_det) begin
        r_busy <= 1'b1;
      end else if (w_sto_det) begin
        r_busy <= 1'b0;
      end
      r_al <= w_al;
    end
  end

  // FSM state and registered pad/status outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_scl_oen  <= 1'b1;
      r_sda_oen  <= 1'b1;
      r_cmd_ack  <= 1'b0;
      r_dout     <= 1'b0;
      r_cmd_stop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_scl_oen  <= w_scl_oen_nxt;
      r_sda_oen  <= w_sda_oen_nxt;
      r_cmd_ack  <= w_cmd_ack_nxt;
      r_dout     <= w_dout_nxt;
      r_cmd_stop <= w_cmd_stop_nxt;
    end
  end

  // Next state and next pad levels; outputs are set for the phase being entered.
  always_comb begin
    w_state_nxt    = r_state;
    w_scl_oen_nxt  = r_scl_oen;
    w_sda_oen_nxt  = r_sda_oen;
    w_cmd_ack_nxt  = 1'b0;
    w_dout_nxt     = r_dout;
    w_cmd_stop_nxt = r_cmd_stop;

    if (!bus.ena || w_al) begin
      w_state_nxt   = S_IDLE;
      w_scl_oen_nxt = 1'b1;
      w_sda_oen_nxt = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_ok) begin
            w_cmd_stop_nxt = (bus.cmd == CMD_STOP);
            case (bus.cmd)
              CMD_START: begin
                w_state_nxt   = S_STA_A;
                w_sda_oen_nxt = 1'b1;
              end
              CMD_STOP: begin
                w_state_nxt   = S_STO_A;
                w_scl_oen_nxt = 1'b0;
                w_sda_oen_nxt = 1'b0;
              end
              CMD_WRITE: begin
                w_state_nxt   = S_WR_A;
                w_scl_oen_nxt = 1'b0;
                w_sda_oen_nxt = bus.din;
              end
              default: begin
                w_state_nxt   = S_RD_A;
                w_scl_oen_nxt = 1'b0;
                w_sda_oen_nxt = 1'b1;
              end
            endcase
          end
        end
        S_STA_A: if (w_clk_en) begin
          w_state_nxt = S_STA_B; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = 1'b1;
        end
        S_STA_B: if (w_clk_en) begin
          w_state_nxt = S_STA_C; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = 1'b0;
        end
        S_STA_C: if (w_clk_en) begin
          w_state_nxt = S_STA_D; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = 1'b0;
        end
        S_STA_D: if (w_clk_en) begin
          w_state_nxt = S_STA_E; w_scl_oen_nxt = 1'b0; w_sda_oen_nxt = 1'b0;
        end
        S_STO_A: if (w_clk_en) begin
          w_state_nxt = S_STO_B; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = 1'b0;
        end
        S_STO_B: if (w_clk_en) begin
          w_state_nxt = S_STO_C; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = 1'b0;
        end
        S_STO_C: if (w_clk_en) begin
          w_state_nxt = S_STO_D; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = 1'b1;
        end
        S_WR_A: if (w_clk_en) begin
          w_state_nxt = S_WR_B; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = bus.din;
        end
        S_WR_B: if (w_clk_en) begin
          w_state_nxt = S_WR_C; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = bus.din;
        end
        S_WR_C: if (w_clk_en) begin
          w_state_nxt = S_WR_D; w_scl_oen_nxt = 1'b0; w_sda_oen_nxt = bus.din;
        end
        S_RD_A: if (w_clk_en) begin
          w_state_nxt = S_RD_B; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = 1'b1;
        end
        S_RD_B: if (w_clk_en) begin
          w_state_nxt = S_RD_C; w_scl_oen_nxt = 1'b1; w_sda_oen_nxt = 1'b1;
          w_dout_nxt  = r_sda_s2;
        end
        S_RD_C: if (w_clk_en) begin
          w_state_nxt = S_RD_D; w_scl_oen_nxt = 1'b0; w_sda_oen_nxt = 1'b1;
        end
        S_STA_E, S_STO_D, S_WR_D, S_RD_D: if (w_clk_en) begin
          w_state_nxt   = S_IDLE;
          w_cmd_ack_nxt = 1'b1;
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_scl_oen_nxt = 1'b1;
          w_sda_oen_nxt = 1'b1;
        end
      endcase
    end
  end

  assign bus.scl_pad_o    = 1'b0;
  assign bus.sda_pad_o    = 1'b0;
  assign bus.scl_padoen_o = r_scl_oen;
  assign bus.sda_padoen_o = r_sda_oen;
  assign bus.cmd_ack      = r_cmd_ack;
  assign bus.dout         = r_dout;
  assign bus.busy         = r_busy;
  assign bus.al           = r_al;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for the I2C bit engine with a wired-AND open-drain bus model.
module tb_i2c_bit_ctrl;

  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_READ  = 4'b1000;

  logic clk;
  logic rst;
  logic slave_scl;
  logic slave_sda;

  int n_checks;
  int n_errors;
  int al_cnt;
  int al_cyc;
  int ack;
  int bad;

  logic log_scl  [0:127];
  logic log_sda  [0:127];
  logic log_busy [0:127];

  i2c_bit_if #(.CNT_W(16)) bus ();

  i2c_bit_ctrl #(.CNT_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  // Open-drain bus: line is low if either side pulls it low.
  assign bus.scl_pad_i = bus.scl_padoen_o & slave_scl;
  assign bus.sda_pad_i = bus.sda_padoen_o & slave_sda;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Presents cmd in the current cycle (cycle 0) and logs outputs until cmd_ack or max_cyc.
  task automatic do_cmd(input logic [3:0] c, input logic d, input int max_cyc,
                        input int scl_st, input int scl_len,
                        input int sda_st, input int sda_len,
                        input int ena_off, output int ack_cyc);
    ack_cyc = -1;
    al_cnt  = 0;
    al_cyc  = -1;
    bus.cmd = c;
    bus.din = d;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      tick();
      slave_scl = !(scl_len > 0 && cyc >= scl_st && cyc < scl_st + scl_len);
      slave_sda = !(sda_len > 0 && cyc >= sda_st && cyc < sda_st + sda_len);
      if (cyc == ena_off) bus.ena = 1'b0;
      log_scl[cyc]  = bus.scl_padoen_o;
      log_sda[cyc]  = bus.sda_padoen_o;
      log_busy[cyc] = bus.busy;
      if (bus.al) begin
        al_cnt++;
        if (al_cyc < 0) al_cyc = cyc;
        bus.cmd = 4'b0000;
      end
      if (bus.cmd_ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    bus.cmd = 4'b0000;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    slave_scl = 1'b1;
    slave_sda = 1'b1;
    bus.ena     = 1'b1;
    bus.clk_cnt = 16'd4;
    bus.cmd     = 4'b0000;
    bus.din     = 1'b0;
    rst         = 1'b1;

    // Reset values
    do_reset();
    check("rst_scl_oen", 32'(bus.scl_padoen_o), 1);
    check("rst_sda_oen", 32'(bus.sda_padoen_o), 1);
    check("rst_cmd_ack", 32'(bus.cmd_ack), 0);
    check("rst_dout",    32'(bus.dout), 0);
    check("rst_busy",    32'(bus.busy), 0);
    check("rst_al",      32'(bus.al), 0);
    check("scl_pad_o",   32'(bus.scl_pad_o), 0);
    check("sda_pad_o",   32'(bus.sda_pad_o), 0);

    // WRITE 1, clk_cnt=4
    do_cmd(C_WRITE, 1'b1, 30, 0, 0, 0, 0, 0, ack);
    check("wr_ack_cycle", 32'(ack), 21);
    bad = 0;
    for (int k = 1; k <= 21; k++)
      if (log_scl[k] !== ((k >= 6 && k <= 15) ? 1'b1 : 1'b0)) bad++;
    check("wr_scl_pattern_bad", 32'(bad), 0);
    bad = 0;
    for (int k = 1; k <= 21; k++)
      if (log_sda[k] !== 1'b1) bad++;
    check("wr_sda_released_bad", 32'(bad), 0);
    check("wr_al_count", 32'(al_cnt), 0);

    // START then STOP, clk_cnt=4
    do_reset();
    do_cmd(C_START, 1'b0, 40, 0, 0, 0, 0, 0, ack);
    check("sta_ack_cycle", 32'(ack), 26);
    check("sta_sda_b", 32'(log_sda[10]), 1);
    check("sta_sda_c", 32'(log_sda[11]), 0);
    check("sta_scl_e", 32'(log_scl[21]), 0);
    check("sta_busy_before", 32'(log_busy[13]), 0);
    check("sta_busy_after",  32'(log_busy[14]), 1);
    do_cmd(C_STOP, 1'b0, 40, 0, 0, 0, 0, 0, ack);
    check("sto_ack_cycle", 32'(ack), 21);
    check("sto_sda_d", 32'(log_sda[16]), 1);
    check("sto_busy_before", 32'(log_busy[18]), 1);
    check("sto_busy_after",  32'(log_busy[19]), 0);
    check("sto_al_count", 32'(al_cnt), 0);

    // READ, clk_cnt=2: released line, then slave holding 0, then released again
    do_reset();
    bus.clk_cnt = 16'd2;
    do_cmd(C_READ, 1'b0, 30, 0, 0, 0, 0, 0, ack);
    check("rd1_ack_cycle", 32'(ack), 13);
    check("rd1_dout", 32'(bus.dout), 1);
    do_cmd(C_READ, 1'b0, 30, 0, 0, 1, 12, 0, ack);
    check("rd0_ack_cycle", 32'(ack), 13);
    check("rd0_dout", 32'(bus.dout), 0);
    check("rd0_al_count", 32'(al_cnt), 0);
    do_cmd(C_READ, 1'b0, 30, 0, 0, 0, 0, 0, ack);
    check("rd1b_dout", 32'(bus.dout), 1);

    // Reset in the middle of a READ
    do_cmd(C_READ, 1'b0, 2, 0, 0, 0, 0, 0, ack);
    check("rdrst_no_ack", 32'(ack), -1);
    check("rdrst_scl_low", 32'(log_scl[2]), 0);
    rst = 1'b1;
    tick();
    check("rdrst_scl_oen", 32'(bus.scl_padoen_o), 1);
    check("rdrst_sda_oen", 32'(bus.sda_padoen_o), 1);
    check("rdrst_dout",    32'(bus.dout), 0);
    check("rdrst_cmd_ack", 32'(bus.cmd_ack), 0);
    check("rdrst_busy",    32'(bus.busy), 0);
    check("rdrst_al",      32'(bus.al), 0);
    rst = 1'b0;

    // Clock stretching: slave holds SCL low for 30 cycles from release
    do_reset();
    bus.clk_cnt = 16'd4;
    do_cmd(C_WRITE, 1'b1, 80, 6, 30, 0, 0, 0, ack);
    check("str_ack_cycle", 32'(ack), 51);
    check("str_al_count", 32'(al_cnt), 0);

    // Arbitration: another master pulls SDA low in phase B of WRITE 1
    do_reset();
    do_cmd(C_WRITE, 1'b1, 30, 0, 0, 6, 25, 0, ack);
    check("arb_no_ack", 32'(ack), -1);
    check("arb_al_count", 32'(al_cnt), 1);
    check("arb_al_cycle", 32'(al_cyc), 9);
    bad = 0;
    for (int k = 10; k <= 30; k++)
      if (log_scl[k] !== 1'b1 || log_sda[k] !== 1'b1) bad++;
    check("arb_pads_released_bad", 32'(bad), 0);
    // Other master releases SDA with SCL high: foreign STOP also flags al
    slave_sda = 1'b1;
    tick();
    tick();
    check("fstop_al_early", 32'(bus.al), 0);
    tick();
    check("fstop_al_pulse", 32'(bus.al), 1);
    tick();
    check("fstop_al_end", 32'(bus.al), 0);

    // ena dropped mid-WRITE
    do_reset();
    do_cmd(C_WRITE, 1'b0, 25, 0, 0, 0, 0, 8, ack);
    check("ena_no_ack", 32'(ack), -1);
    bad = 0;
    for (int k = 9; k <= 25; k++)
      if (log_scl[k] !== 1'b1 || log_sda[k] !== 1'b1) bad++;
    check("ena_pads_released_bad", 32'(bad), 0);
    bus.ena = 1'b1;

    // clk_cnt=0: single-cycle phases
    do_reset();
    bus.clk_cnt = 16'd0;
    do_cmd(C_WRITE, 1'b0, 20, 0, 0, 0, 0, 0, ack);
    check("cc0_ack_cycle", 32'(ack), 5);
    check("cc0_scl_a", 32'(log_scl[1]), 0);
    check("cc0_scl_b", 32'(log_scl[2]), 1);
    check("cc0_scl_d", 32'(log_scl[4]), 0);
    check("cc0_sda_a", 32'(log_sda[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
